sev_seg_scroll_ctrl: RTL

- Marquee controller for the 8-digit seven-segment display.
- Buffers up to MSG_LEN hex characters entered from SW[3:0].
- Time-multiplexes the digits and scrolls the message across the display with 8 trailing blanks.
- Sits between the switch/button inputs and the SSEG_CA/SSEG_AN pins, and replaces the static sev_seg decoder on the board top level.

---
 rtl/sev_seg_scroll_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sev_seg_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sev_seg_scroll_ctrl
// Brief   : 8-digit seven-segment marquee with hex message buffer and scroll.
// Revision: 1.0
// ============================================================================
module sev_seg_scroll_ctrl #(
  parameter int SCAN_DIV   = 100000,
  parameter int SCROLL_DIV = 50000000,
  parameter int MSG_LEN    = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] SW,
  input  logic       WR_EN,
  input  logic       CLR,
  input  logic       RUN,
  input  logic       DIR,
  output logic [7:0] SSEG_CA,
  output logic [7:0] SSEG_AN,
  output logic [3:0] LED
);

  localparam int LW       = $clog2(MSG_LEN + 1);
  localparam int IW       = $clog2(MSG_LEN);
  localparam int OW       = $clog2(MSG_LEN + 8);
  localparam int PW       = OW + 1;
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [LW-1:0]       LEN_FULL   = LW'(MSG_LEN);
  localparam logic [SCAN_W-1:0]   SCAN_MAX   = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_MAX = SCROLL_W'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SCROLL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       len_q, len_d;
  logic [OW-1:0]       offset_q, offset_d;
  logic [2:0]          k_q, k_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [SCROLL_W-1:0] scroll_cnt_q, scroll_cnt_d;
  logic [7:0]          an_q, an_d;
  logic [7:0]          ca_q, ca_d;
  logic [3:0]          led_q, led_d;
  logic [3:0]          buf_q [MSG_LEN];

  logic          buf_wr;
  logic          scan_wrap;
  logic          scroll_tick;
  logic [OW-1:0] offset_last;
  logic [PW-1:0] pos_sum;
  logic [PW-1:0] ring_len;
  logic [PW-1:0] pos;

  function automatic logic [7:0] seg_decode(input logic [3:0] c);
    logic [7:0] s;
    case (c)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign scroll_tick = (state_q == ST_SCROLL) && (scroll_cnt_q == SCROLL_MAX);
  assign offset_last = OW'(len_q) + OW'(7);
  assign scan_wrap   = (scan_cnt_q == SCAN_MAX);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    offset_d = offset_q;
    buf_wr   = 1'b0;
    if (CLR) begin
      state_d  = ST_IDLE;
      len_d    = '0;
      offset_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (WR_EN) begin
            buf_wr  = 1'b1;
            len_d   = len_q + 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (WR_EN && (len_q < LEN_FULL)) begin
            buf_wr = 1'b1;
            len_d  = len_q + 1'b1;
          end
          if (RUN && (len_q != '0)) begin
            state_d = ST_SCROLL;
          end
        end
        ST_SCROLL: begin
          // Leaving scroll takes precedence over a coincident tick.
          if (!RUN) begin
            state_d  = ST_HOLD;
            offset_d = '0;
          end else if (scroll_tick) begin
            if (!DIR) begin
              offset_d = (offset_q == offset_last) ? '0 : offset_q + 1'b1;
            end else begin
              offset_d = (offset_q == '0) ? offset_last : offset_q - 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    scan_cnt_d   = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    k_d          = scan_wrap ? k_q + 3'd1 : k_q;
    scroll_cnt_d = ((state_q == ST_SCROLL) && !scroll_tick) ? scroll_cnt_q + 1'b1 : '0;
  end

  // offset+k never exceeds two ring lengths, so one conditional subtract wraps it.
  always_comb begin
    pos_sum  = PW'(offset_q) + PW'(k_q);
    ring_len = PW'(len_q) + PW'(8);
    pos      = (pos_sum >= ring_len) ? pos_sum - ring_len : pos_sum;
    ca_d     = (pos < PW'(len_q)) ? seg_decode(buf_q[pos[IW-1:0]]) : 8'hFF;
    an_d     = ~(8'h80 >> k_q);
    led_d    = {len_d == LEN_FULL, state_d == ST_SCROLL,
                state_d == ST_HOLD, state_d == ST_IDLE};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      offset_q     <= '0;
      k_q          <= '0;
      scan_cnt_q   <= '0;
      scroll_cnt_q <= '0;
      an_q         <= 8'hFF;
      ca_q         <= 8'hFF;
      led_q        <= 4'b0001;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      offset_q     <= offset_d;
      k_q          <= k_d;
      scan_cnt_q   <= scan_cnt_d;
      scroll_cnt_q <= scroll_cnt_d;
      an_q         <= an_d;
      ca_q         <= ca_d;
      led_q        <= led_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (buf_wr) begin
      buf_q[len_q[IW-1:0]] <= SW;
    end
  end

  assign SSEG_AN = an_q;
  assign SSEG_CA = ca_q;
  assign LED     = led_q;

endmodule
`default_nettype wire
